ram_port_arbiter: RTL and testbench

- Shares the single 4-bit data RAM between two requesters: port 0 (CPU datapath load/store) and port 1 (host/debug loader).
- Owns all RAM control: chip select, write enable, address and write data.
- Arbitrates round-robin, latches the winning request, holds RAM controls stable for a fixed access window, then returns read data with a one-cycle done pulse.
- Sits between the CPU datapath and the RAM/tri-state buffer pair at the top level.

---
 rtl/ram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter owning the shared data RAM: latches the winner, holds
// the RAM controls for ACC_CYC cycles, then pulses done. Define ARB_CPU_PRIORITY_EN for fixed port-0 priority.
module ram_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 4,
  parameter int ACC_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cntNext;
  logic              r_last;
  logic              w_lastNext;
  logic              r_win;
  logic              w_winNext;
  logic              w_anyReq;
  logic              w_pick;

  logic              r_gnt0, r_gnt1, r_done0, r_done1;
  logic              w_gnt0Next, w_gnt1Next, w_done0Next, w_done1Next;
  logic [DATA_W-1:0] r_rdata, w_rdataNext;
  logic [ADDR_W-1:0] r_ramAddr, w_ramAddrNext;
  logic [DATA_W-1:0] r_ramWdata, w_ramWdataNext;
  logic              r_ramCs, w_ramCsNext;
  logic              r_ramWe, w_ramWeNext;
  logic              r_busy, w_busyNext;

  assign w_anyReq = req0 | req1;

  // r_last remembers the previous winner so a tie goes to the other port
`ifdef ARB_CPU_PRIORITY_EN
  assign w_pick = req0 ? 1'b0 : 1'b1;
`else
  assign w_pick = (req0 && req1) ? ~r_last : req1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_stateNext = ACCESS;
      ACCESS:  if (r_cnt == 4'd0) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_gnt0Next     = 1'b0;
    w_gnt1Next     = 1'b0;
    w_done0Next    = 1'b0;
    w_done1Next    = 1'b0;
    w_rdataNext    = r_rdata;
    w_ramAddrNext  = r_ramAddr;
    w_ramWdataNext = r_ramWdata;
    w_ramCsNext    = r_ramCs;
    w_ramWeNext    = r_ramWe;
    w_busyNext     = r_busy;
    w_cntNext      = r_cnt;
    w_lastNext     = r_last;
    w_winNext      = r_win;
    case (r_state)
      IDLE: begin
        w_ramCsNext = 1'b0;
        if (w_anyReq) begin
          w_winNext      = w_pick;
          w_ramAddrNext  = w_pick ? addr1  : addr0;
          w_ramWdataNext = w_pick ? wdata1 : wdata0;
          w_ramWeNext    = w_pick ? we1    : we0;
          w_ramCsNext    = 1'b1;
          w_gnt0Next     = ~w_pick;
          w_gnt1Next     = w_pick;
          w_busyNext     = 1'b1;
          w_cntNext      = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cntNext = r_cnt - 4'd1;
        end else begin
          // ram_we still holds the access direction on this final edge
          if (!r_ramWe) w_rdataNext = ram_rdata;
          w_ramCsNext = 1'b0;
          w_ramWeNext = 1'b0;
          w_done0Next = ~r_win;
          w_done1Next = r_win;
          w_lastNext  = r_win;
        end
      end
      DONE: begin
        w_ramCsNext = 1'b0;
        w_busyNext  = 1'b0;
      end
      default: begin
        w_ramCsNext = 1'b0;
        w_ramWeNext = 1'b0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_rdata    <= '0;
      r_ramAddr  <= '0;
      r_ramWdata <= '0;
      r_ramCs    <= 1'b0;
      r_ramWe    <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= 4'd0;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
    end else begin
      r_gnt0     <= w_gnt0Next;
      r_gnt1     <= w_gnt1Next;
      r_done0    <= w_done0Next;
      r_done1    <= w_done1Next;
      r_rdata    <= w_rdataNext;
      r_ramAddr  <= w_ramAddrNext;
      r_ramWdata <= w_ramWdataNext;
      r_ramCs    <= w_ramCsNext;
      r_ramWe    <= w_ramWeNext;
      r_busy     <= w_busyNext;
      r_cnt      <= w_cntNext;
      r_last     <= w_lastNext;
      r_win      <= w_winNext;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata     = r_rdata;
  assign ram_addr  = r_ramAddr;
  assign ram_wdata = r_ramWdata;
  assign ram_cs    = r_ramCs;
  assign ram_we    = r_ramWe;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM; ACC_CYC fixed at 3.
module tb_ram_port_arbiter;

  localparam int ACC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [3:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, ram_cs, ram_we, busy;
  logic [3:0]  rdata, ram_wdata, ram_rdata;
  logic [11:0] ram_addr;
  logic [3:0]  mem [0:4095];
  int          numChecks = 0;
  int          numFails  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(12), .DATA_W(4), .ACC_CYC(ACC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .busy(busy)
  );

  // behavioural RAM, cleared on reset with one preset location
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 4'h0;
      mem[12'h011] <= 4'h6;
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [11:0] a0, input logic [3:0] d0,
                               input logic r1, input logic w1, input logic [11:0] a1, input logic [3:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // one full access from the grant edge through the return to IDLE
  task automatic doAccessCheck(input string tag, input int port, input logic expWe, input logic [11:0] expAddr);
    tick();
    checkOutput({tag, " gnt0"}, 32'(gnt0), 32'(port == 0));
    checkOutput({tag, " gnt1"}, 32'(gnt1), 32'(port == 1));
    checkOutput({tag, " cs"}, 32'(ram_cs), 32'd1);
    checkOutput({tag, " we"}, 32'(ram_we), 32'(expWe));
    checkOutput({tag, " addr"}, 32'(ram_addr), 32'(expAddr));
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 1; i < ACC; i++) begin
      tick();
      checkOutput({tag, " cs window"}, 32'(ram_cs), 32'd1);
      checkOutput({tag, " addr window"}, 32'(ram_addr), 32'(expAddr));
      checkOutput({tag, " gnt pulse"}, 32'(gnt0 | gnt1), 32'd0);
    end
    tick();
    checkOutput({tag, " cs end"}, 32'(ram_cs), 32'd0);
    checkOutput({tag, " we end"}, 32'(ram_we), 32'd0);
    checkOutput({tag, " done0"}, 32'(done0), 32'(port == 0));
    checkOutput({tag, " done1"}, 32'(done1), 32'(port == 1));
    tick();
    checkOutput({tag, " done clear"}, 32'(done0 | done1), 32'd0);
    checkOutput({tag, " idle cs"}, 32'(ram_cs), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int expOrder [6];
    // reset state
    reset = 1'b1;
    applyStimulus(0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0);
    tick();
    tick();
    checkOutput("reset outputs", {gnt0, gnt1, done0, done1, ram_cs, ram_we, busy, 25'd0}, 32'd0);
    checkOutput("reset rdata", 32'(rdata), 32'd0);
    checkOutput("reset addr", 32'(ram_addr), 32'd0);
    checkOutput("reset wdata", 32'(ram_wdata), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle no req cs", 32'(ram_cs), 32'd0);

    // test 1: port 0 write
    applyStimulus(1, 1, 12'h005, 4'hA, 0, 0, 12'h000, 4'h0);
    tick();
    checkOutput("t1 gnt0", 32'(gnt0), 32'd1);
    checkOutput("t1 cs", 32'(ram_cs), 32'd1);
    checkOutput("t1 we", 32'(ram_we), 32'd1);
    checkOutput("t1 addr", 32'(ram_addr), 32'h005);
    checkOutput("t1 wdata", 32'(ram_wdata), 32'hA);
    req0 = 1'b0;
    for (int i = 1; i < ACC; i++) begin
      tick();
      checkOutput("t1 cs window", 32'(ram_cs), 32'd1);
      checkOutput("t1 gnt0 pulse", 32'(gnt0), 32'd0);
    end
    tick();
    checkOutput("t1 done0", 32'(done0), 32'd1);
    checkOutput("t1 cs off", 32'(ram_cs), 32'd0);
    checkOutput("t1 rdata", 32'(rdata), 32'd0);
    tick();
    checkOutput("t1 done0 clear", 32'(done0), 32'd0);
    checkOutput("t1 busy clear", 32'(busy), 32'd0);

    // test 2: port 1 read, address changed after grant
    applyStimulus(0, 0, 12'h000, 4'h0, 1, 0, 12'h005, 4'h3);
    tick();
    checkOutput("t2 gnt1", 32'(gnt1), 32'd1);
    checkOutput("t2 gnt0", 32'(gnt0), 32'd0);
    checkOutput("t2 we", 32'(ram_we), 32'd0);
    addr1 = 12'h7FF;
    req1  = 1'b0;
    for (int i = 1; i < ACC; i++) begin
      tick();
      checkOutput("t2 cs window", 32'(ram_cs), 32'd1);
      checkOutput("t2 addr held", 32'(ram_addr), 32'h005);
    end
    tick();
    checkOutput("t2 cs off", 32'(ram_cs), 32'd0);
    checkOutput("t2 done1", 32'(done1), 32'd1);
    checkOutput("t2 rdata", 32'(rdata), 32'hA);
    tick();
    checkOutput("t2 done1 clear", 32'(done1), 32'd0);

    // test 3 / 6: both requesting continuously
`ifdef ARB_CPU_PRIORITY_EN
    expOrder = '{0, 0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 0, 1, 0, 1};
`endif
    applyStimulus(1, 1, 12'h010, 4'h3, 1, 0, 12'h011, 4'h0);
    for (int n = 0; n < 6; n++) begin
      doAccessCheck($sformatf("t3 acc%0d", n), expOrder[n], (expOrder[n] == 0), (expOrder[n] == 0) ? 12'h010 : 12'h011);
    end
    req0 = 1'b0;
    doAccessCheck("t6 port1 after drop", 1, 1'b0, 12'h011);
    checkOutput("t6 rdata", 32'(rdata), 32'h6);
    req1 = 1'b0;

    // test 4: reset mid-access, then both pending; port 0 must win
    applyStimulus(1, 1, 12'h0AB, 4'h9, 1, 0, 12'h011, 4'h0);
    tick();
    checkOutput("t4 gnt0", 32'(gnt0), 32'd1);
    tick();
    checkOutput("t4 cs before reset", 32'(ram_cs), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t4 cs async", 32'(ram_cs), 32'd0);
    checkOutput("t4 we async", 32'(ram_we), 32'd0);
    checkOutput("t4 busy async", 32'(busy), 32'd0);
    tick();
    checkOutput("t4 no done", 32'(done0 | done1), 32'd0);
    reset = 1'b0;
    doAccessCheck("t4 after reset", 0, 1'b1, 12'h0AB);
    req1 = 1'b0;

    // test 5: port 1 withdraws before grant while port 0 is busy
    applyStimulus(1, 0, 12'h0AB, 4'h0, 0, 0, 12'h000, 4'h0);
    tick();
    checkOutput("t5 gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0CD;
    tick();
    checkOutput("t5 no gnt1 a", 32'(gnt1), 32'd0);
    req1 = 1'b0;
    tick();
    checkOutput("t5 cs window", 32'(ram_cs), 32'd1);
    tick();
    checkOutput("t5 done0", 32'(done0), 32'd1);
    checkOutput("t5 rdata", 32'(rdata), 32'h9);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t5 no gnt1", 32'(gnt1), 32'd0);
      checkOutput("t5 no done1", 32'(done1), 32'd0);
      checkOutput("t5 idle cs", 32'(ram_cs), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
